modulate: RTL
=============

# modulate

Transmit-side counterpart of the demodulation chain. Accepts complex baseband samples at the symbol rate through a valid/ready handshake, zero-stuff upsamples by UPSAMPLE, applies a 32-tap interpolation FIR with a programmable coefficient bank, and mixes the result with an externally supplied LO. It produces one 10-bit complex modulated sample per clock, in the same fixed-point format the demodulator consumes.

## Interface
- DATA_W, 10, sample and LO width (signed)
- COEF_W, 12, FIR coefficient width (signed, Q1.11)
- TAPS, 32, FIR length
- UPSAMPLE, 8, interpolation factor (≥2)
- SHIFT, 11, FIR accumulator right shift
- clock  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- sym_real / sym_imag  in  DATA_W  baseband input sample
- sym_valid  in  1  input sample present
- sym_ready  out  1  block accepts sample this cycle
- coef_wr_en  in  1  coefficient write strobe
- coef_addr  in  5  tap index 0..TAPS-1
- coef_data  in  COEF_W  coefficient value
- mod_Lo_real / mod_Lo_imag  in  DATA_W  LO sample, Q1.9
- sig_modulated_real / sig_modulated_imag  out  DATA_W  modulated output
- out_valid  out  1  output sample valid
- overflow  out  1  sticky: any saturation occurred
- underrun  out  1  sticky: zero inserted at a symbol slot with no input

## Operation
- States: IDLE, RUN.
- IDLE: sym_ready=1. Delay line frozen. out_valid=0. On transfer (sym_valid & sym_ready): sample written to tap 0, phase←1, → RUN.
- RUN: delay line shifts every cycle. Phase counter 0..UPSAMPLE-1 wraps. sym_ready=1 only at phase 0.
  - Phase 0 with valid: sample enters tap 0.
  - Phase 0 without valid: zero enters, underrun←1.
  - Phase ≠0: zero enters. sym_valid is ignored.
- RUN is left only by rst.
- FIR, per I and Q: acc = Σ coef[k]·x[n−k], 27-bit signed. filt = sat_DATA_W((acc + 2^(SHIFT−1)) >>> SHIFT).
- Mixer:
  - real = filt_r·Lo_r − filt_i·Lo_i
  - imag = filt_r·Lo_i + filt_i·Lo_r
  - Each term is 21-bit. Output = sat_DATA_W((p + 256) >>> 9).
- Saturation clamps to +511 / −512. Any clamp in the FIR or mixer sets overflow.
- Coefficient write: coef[coef_addr] ← coef_data at the edge and is used from the next cycle onward. Writes are legal in any state. A write during RUN is not glitch-protected.
- rst clears: delay line, coefficients (to 0), phase, state (→IDLE), both output registers, out_valid, overflow, underrun.

## Timing
- Reset values:
  - sig_modulated_real/imag = 0
  - out_valid = 0
  - overflow = 0
  - underrun = 0
  - sym_ready = 1
- Latency: a sample transferred at edge E0 contributes via tap 0 to the FIR register at E0+1 and appears on sig_modulated at E0+2.
- The LO is sampled at the mixer-register edge (E0+2). The LO must be aligned to the output sample, not the input.
- out_valid rises at E0+2 after the first transfer and stays high thereafter until rst.
- Throughput: at most one transfer per UPSAMPLE cycles. With sym_valid held high, sym_ready is a one-cycle pulse every UPSAMPLE cycles.
- rst asserted mid-RUN: all state is cleared at that edge. sym_ready=1 in the following cycle, and no stale sample reaches the output.

## Structure
- Package modulate_pkg holds:
  - DATA_W, COEF_W, TAPS, ACC_W (27), LO_FRAC (9)
  - a sat_data(signed acc) function returning DATA_W with an overflow flag
- Sub-module interp_fir: delay line plus MAC tree plus round/saturate. It is instantiated twice (I, Q) sharing one coefficient bank owned by modulate.
- The phase counter, FSM, mixer and sticky flags live in the top module.

## Test plan
- Reset: hold rst 2 cycles → outputs 0, out_valid=0, sym_ready=1, flags 0.
- Impulse:
  - Setup: coef[k]=1024 for all k; LO=(256,0); one transfer real=200, imag=0; sym_valid low afterward.
  - Required response: from E0+2, 32 consecutive outputs of real=50, imag=0, then zeros. underrun=1 after the next phase-0 slot.
- LO rotation: same impulse with LO=(0,256) → real=0, imag=50 for 32 cycles.
- Cadence: sym_valid held high, incrementing data → sym_ready pulses every 8 cycles. Exactly one transfer per pulse, no duplicates or drops, underrun stays 0.
- Saturation: coef[k]=2047 for all k; continuous input 511; LO=(511,0) → filt clamps at 511, sig_modulated_real=510, overflow=1 and stays set.
- Reset mid-run: pulse rst during RUN → next cycle outputs 0, out_valid=0, flags cleared, coefficients 0. A new transfer restarts with E0+2 latency.

Source files
------------

// File: rtl/modulate_pkg.sv
// Shared constants, FSM state type and saturation helper for the modulate transmit chain.
// Pure declarations; no timing of its own.
// No flow control here; consumers apply it.
package modulate_pkg;

  localparam int DATA_W   = 10;
  localparam int COEF_W   = 12;
  localparam int TAPS     = 32;
  localparam int UPSAMPLE = 8;
  localparam int SHIFT    = 11;
  localparam int ACC_W    = 27;
  localparam int LO_FRAC  = 9;
  localparam int PH_W     = $clog2(UPSAMPLE);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic                     ovf;
    logic signed [DATA_W-1:0] val;
  } sat_t;

  localparam logic signed [DATA_W-1:0] DATA_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] DATA_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  // Clamp a wide signed value into DATA_W bits, flagging when a clamp happened.
  function automatic sat_t sat_data(input logic signed [ACC_W-1:0] acc);
    sat_t r;
    r.ovf = 1'b0;
    r.val = acc[DATA_W-1:0];
    if (acc > ACC_W'(DATA_MAX)) begin
      r.ovf = 1'b1;
      r.val = DATA_MAX;
    end else if (acc < ACC_W'(DATA_MIN)) begin
      r.ovf = 1'b1;
      r.val = DATA_MIN;
    end
    return r;
  endfunction

endpackage

// File: rtl/modulate_interp_fir.sv
// Interpolation FIR for one rail: delay line, MAC sum, round and saturate into a register.
// One cycle from tap 0 to o_filt.
// No backpressure; the delay line shifts whenever i_shift_en is high.
module interp_fir
  import modulate_pkg::*;
(
  input  logic                          clock,
  input  logic                          rst,
  input  logic                          i_shift_en,
  input  logic signed [DATA_W-1:0]      i_sample,
  input  logic [TAPS-1:0][COEF_W-1:0]   i_coef,
  output logic signed [DATA_W-1:0]      o_filt,
  output logic                          o_sat
);

  logic [TAPS-1:0][DATA_W-1:0] r_tap;
  logic signed [DATA_W-1:0]    r_filt;
  logic signed [ACC_W-1:0]     w_acc;
  logic signed [ACC_W-1:0]     w_rnd;
  sat_t                        w_sat;

  // Delay line: newest sample in tap 0, oldest falls off the end.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_tap <= '0;
    end else if (i_shift_en) begin
      r_tap <= {r_tap[TAPS-2:0], i_sample};
    end
  end

  // Sum of products, then round-half-up and clamp to the sample width.
  always_comb begin
    w_acc = '0;
    for (int k = 0; k < TAPS; k++) begin
      w_acc = w_acc + ACC_W'($signed(r_tap[k]) * $signed(i_coef[k]));
    end
    w_rnd = (w_acc + ACC_W'(1 <<< (SHIFT-1))) >>> SHIFT;
    w_sat = sat_data(w_rnd);
  end

  // Filter output register; the clamp flag is reported in the cycle it is captured.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_filt <= '0;
    end else begin
      r_filt <= w_sat.val;
    end
  end

  assign o_filt = r_filt;
  assign o_sat  = w_sat.ovf;

endmodule

// File: rtl/modulate.sv
// Transmit modulator: zero-stuff upsample, 32-tap interpolation FIR per rail, complex LO mix.
// A sample accepted at edge E0 reaches sig_modulated at E0+2; LO sampled at that output edge.
// sym_ready is high in IDLE and only at phase 0 in RUN: one accept per UPSAMPLE cycles.
module modulate
  import modulate_pkg::*;
(
  input  logic                     clock,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] sym_real,
  input  logic signed [DATA_W-1:0] sym_imag,
  input  logic                     sym_valid,
  output logic                     sym_ready,
  input  logic                     coef_wr_en,
  input  logic [4:0]               coef_addr,
  input  logic [COEF_W-1:0]        coef_data,
  input  logic signed [DATA_W-1:0] mod_Lo_real,
  input  logic signed [DATA_W-1:0] mod_Lo_imag,
  output logic signed [DATA_W-1:0] sig_modulated_real,
  output logic signed [DATA_W-1:0] sig_modulated_imag,
  output logic                     out_valid,
  output logic                     overflow,
  output logic                     underrun
);

  localparam int MIX_W = 2*DATA_W + 1;

  state_t                      r_state, w_state_nxt;
  logic [PH_W-1:0]             r_phase, w_phase_nxt;
  logic                        w_shift_en;
  logic                        w_underrun_set;
  logic                        w_xfer;
  logic [TAPS-1:0][COEF_W-1:0] r_coef;
  logic signed [DATA_W-1:0]    w_samp_r, w_samp_i;
  logic signed [DATA_W-1:0]    w_filt_r, w_filt_i;
  logic                        w_fsat_r, w_fsat_i;
  logic                        r_fir_vld;
  logic                        r_out_vld;
  logic signed [DATA_W-1:0]    r_out_r, r_out_i;
  logic                        r_overflow, r_underrun;
  logic signed [2*DATA_W-1:0]  w_p_rr, w_p_ii, w_p_ri, w_p_ir;
  logic signed [MIX_W-1:0]     w_mix_r, w_mix_i;
  logic signed [ACC_W-1:0]     w_mrnd_r, w_mrnd_i;
  sat_t                        w_msat_r, w_msat_i;

  // State and phase registers.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_phase <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
    end
  end

  // Next state, phase advance, handshake and zero-stuffing decisions.
  always_comb begin
    w_state_nxt    = r_state;
    w_phase_nxt    = r_phase;
    sym_ready      = 1'b0;
    w_shift_en     = 1'b0;
    w_underrun_set = 1'b0;
    case (r_state)
      ST_IDLE: begin
        sym_ready = 1'b1;
        if (sym_valid) begin
          w_state_nxt = ST_RUN;
          w_phase_nxt = PH_W'(1);
          w_shift_en  = 1'b1;
        end
      end
      ST_RUN: begin
        w_shift_en  = 1'b1;
        sym_ready   = (r_phase == '0);
        w_phase_nxt = (r_phase == PH_W'(UPSAMPLE-1)) ? '0 : r_phase + PH_W'(1);
        if ((r_phase == '0) && !sym_valid) begin
          w_underrun_set = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_xfer   = sym_valid & sym_ready;
  assign w_samp_r = w_xfer ? sym_real : '0;
  assign w_samp_i = w_xfer ? sym_imag : '0;

  // Coefficient bank shared by both rails; a write takes effect the cycle after.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_coef <= '0;
    end else if (coef_wr_en) begin
      r_coef[coef_addr] <= coef_data;
    end
  end

  interp_fir u_fir_r (
    .clock      (clock),
    .rst        (rst),
    .i_shift_en (w_shift_en),
    .i_sample   (w_samp_r),
    .i_coef     (r_coef),
    .o_filt     (w_filt_r),
    .o_sat      (w_fsat_r)
  );

  interp_fir u_fir_i (
    .clock      (clock),
    .rst        (rst),
    .i_shift_en (w_shift_en),
    .i_sample   (w_samp_i),
    .i_coef     (r_coef),
    .o_filt     (w_filt_i),
    .o_sat      (w_fsat_i)
  );

  // Complex multiply by the LO, round-half-up by 2^LO_FRAC, clamp.
  always_comb begin
    w_p_rr   = w_filt_r * mod_Lo_real;
    w_p_ii   = w_filt_i * mod_Lo_imag;
    w_p_ri   = w_filt_r * mod_Lo_imag;
    w_p_ir   = w_filt_i * mod_Lo_real;
    w_mix_r  = MIX_W'(w_p_rr) - MIX_W'(w_p_ii);
    w_mix_i  = MIX_W'(w_p_ri) + MIX_W'(w_p_ir);
    w_mrnd_r = (ACC_W'(w_mix_r) + ACC_W'(1 <<< (LO_FRAC-1))) >>> LO_FRAC;
    w_mrnd_i = (ACC_W'(w_mix_i) + ACC_W'(1 <<< (LO_FRAC-1))) >>> LO_FRAC;
    w_msat_r = sat_data(w_mrnd_r);
    w_msat_i = sat_data(w_mrnd_i);
  end

  // Output register, valid pipeline (FSM -> FIR -> mixer) and sticky flags.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_out_r    <= '0;
      r_out_i    <= '0;
      r_fir_vld  <= 1'b0;
      r_out_vld  <= 1'b0;
      r_overflow <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_out_r    <= w_msat_r.val;
      r_out_i    <= w_msat_i.val;
      r_fir_vld  <= (r_state == ST_RUN);
      r_out_vld  <= r_fir_vld;
      r_overflow <= r_overflow | w_fsat_r | w_fsat_i | w_msat_r.ovf | w_msat_i.ovf;
      r_underrun <= r_underrun | w_underrun_set;
    end
  end

  assign sig_modulated_real = r_out_r;
  assign sig_modulated_imag = r_out_i;
  assign out_valid          = r_out_vld;
  assign overflow           = r_overflow;
  assign underrun           = r_underrun;

endmodule
